// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the load/store stage:
// access sizes, exception causes, FSM states.
package mem_access_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_TIMEOUT  = 2'b10,
    EXC_ILLEGAL  = 2'b11
  } exc_cause_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_REQ      = 2'b01,
    S_WAIT_RSP = 2'b10,
    S_RESP     = 2'b11
  } state_e;

  function automatic logic f3_legal(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/gnt/rvalid port.
// master = load/store stage, slave = memory.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr,
    output dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr,
    input  dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage_align.sv
// Byte-lane logic: store enables/data, load
// lane extraction and extension, access checks.
module mem_access_stage_align
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]  i_st_off,
  input  logic [2:0]  i_st_f3,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic [31:0] i_sd,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  output logic        o_illegal,
  input  logic [1:0]  i_ld_off,
  input  logic [2:0]  i_ld_f3,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic        w_st_b;
  logic        w_st_h;
  logic        w_st_w;
  logic [31:0] w_lane;

  assign w_st_b = (i_st_f3[1:0] == 2'b00);
  assign w_st_h = (i_st_f3[1:0] == 2'b01);
  assign w_st_w = (i_st_f3[1:0] == 2'b10);

  assign o_illegal = ~f3_legal(i_st_f3)
                   | (i_wr & i_st_f3[2])
                   | (i_rd & i_wr);

  assign o_misaligned = (w_st_h & i_st_off[0])
                      | (w_st_w & (i_st_off != 2'b00));

  // Store lane enables and replicated data
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0;
    unique case (1'b1)
      w_st_b: begin
        o_be    = 4'b0001 << i_st_off;
        o_wdata = {4{i_sd[7:0]}};
      end
      w_st_h: begin
        o_be    = 4'b0011 << i_st_off;
        o_wdata = {2{i_sd[15:0]}};
      end
      w_st_w: begin
        o_be    = 4'b1111;
        o_wdata = i_sd;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = 32'h0;
      end
    endcase
  end

  assign w_lane = i_rdata >> {i_ld_off, 3'b000};

  // Load lane extension by size/signedness
  always_comb begin
    o_ld_data = i_rdata;
    unique case (i_ld_f3[1:0])
      2'b00: o_ld_data = i_ld_f3[2]
        ? {24'h0, w_lane[7:0]}
        : {{24{w_lane[7]}}, w_lane[7:0]};
      2'b01: o_ld_data = i_ld_f3[2]
        ? {16'h0, w_lane[15:0]}
        : {{16{w_lane[15]}}, w_lane[15:0]};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Load/store stage: drives the data-memory port
// and emits one registered writeback beat per op.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         alu_result,
  input  logic [31:0]         store_data,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [2:0]          funct3,
  input  logic [4:0]          rd_in,
  input  logic                reg_write_in,
  mem_access_stage_if.master  dmem,
  output logic                wb_valid,
  output logic                wb_reg_write,
  output logic [4:0]          wb_rd,
  output logic [31:0]         wb_data,
  output logic                exc_valid,
  output logic [1:0]          exc_cause
);

  localparam logic [31:0] LP_LAST =
    32'(TIMEOUT_CYCLES - 1);

  state_e      r_state;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;
  logic        r_rw;
  logic        r_store;
  logic [31:0] r_timer;
  logic [31:0] r_ld;
  logic        r_exc;
  exc_cause_e  r_cause;
  logic        r_wb_valid;
  logic        r_wb_rw;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_exc_valid;
  exc_cause_e  r_exc_cause;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_mis;
  logic        w_ill;
  logic [31:0] w_ld;
  logic        w_mem;
  logic        w_op_pass;
  logic        w_op_ill;
  logic        w_op_mis;
  logic        w_tmo;

  mem_access_stage_align u_align (
    .i_st_off     (alu_result[1:0]),
    .i_st_f3      (funct3),
    .i_rd         (mem_read),
    .i_wr         (mem_write),
    .i_sd         (store_data),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_mis),
    .o_illegal    (w_ill),
    .i_ld_off     (r_off),
    .i_ld_f3      (r_f3),
    .i_rdata      (dmem.dmem_rdata),
    .o_ld_data    (w_ld)
  );

  assign in_ready  = (r_state == S_IDLE);
  assign w_mem     = mem_read | mem_write;
  assign w_op_pass = ~w_mem;
  assign w_op_ill  = w_mem & w_ill;
  assign w_op_mis  = w_mem & ~w_ill & w_mis;
  assign w_tmo     = (TIMEOUT_CYCLES != 0)
                   && (r_timer == LP_LAST);

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_be    = r_be;
  assign dmem.dmem_wdata = r_wdata;

  assign wb_valid     = r_wb_valid;
  assign wb_reg_write = r_wb_rw;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign exc_valid    = r_exc_valid;
  assign exc_cause    = r_exc_cause;

  // Op capture, bus FSM, timeout and writeback beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'h0;
      r_be        <= 4'h0;
      r_wdata     <= 32'h0;
      r_off       <= 2'b00;
      r_f3        <= 3'b000;
      r_rd        <= 5'd0;
      r_rw        <= 1'b0;
      r_store     <= 1'b0;
      r_timer     <= 32'h0;
      r_ld        <= 32'h0;
      r_exc       <= 1'b0;
      r_cause     <= EXC_NONE;
      r_wb_valid  <= 1'b0;
      r_wb_rw     <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= 32'h0;
      r_exc_valid <= 1'b0;
      r_exc_cause <= EXC_NONE;
    end else begin
      r_wb_valid  <= 1'b0;
      r_wb_rw     <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= 32'h0;
      r_exc_valid <= 1'b0;
      r_exc_cause <= EXC_NONE;
      unique case (r_state)
        S_IDLE: if (in_valid) begin
          r_off   <= alu_result[1:0];
          r_f3    <= funct3;
          r_rd    <= rd_in;
          r_rw    <= reg_write_in;
          r_store <= mem_write;
          r_timer <= 32'h0;
          r_ld    <= 32'h0;
          r_exc   <= 1'b0;
          r_cause <= EXC_NONE;
          unique case (1'b1)
            w_op_pass: begin
              r_wb_valid <= 1'b1;
              r_wb_rw    <= reg_write_in;
              r_wb_rd    <= rd_in;
              r_wb_data  <= alu_result;
            end
            w_op_ill: begin
              r_wb_valid  <= 1'b1;
              r_exc_valid <= 1'b1;
              r_exc_cause <= EXC_ILLEGAL;
            end
            w_op_mis: begin
              r_wb_valid  <= 1'b1;
              r_exc_valid <= 1'b1;
              r_exc_cause <= EXC_MISALIGN;
            end
            default: begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
              r_we    <= mem_write;
              r_addr  <= {alu_result[31:2], 2'b00};
              r_be    <= w_be;
              r_wdata <= mem_write ? w_wdata : 32'h0;
            end
          endcase
        end
        S_REQ: if (dmem.dmem_gnt) begin
          r_req   <= 1'b0;
          r_we    <= 1'b0;
          r_state <= r_store ? S_RESP : S_WAIT_RSP;
        end
        S_WAIT_RSP: begin
          if (dmem.dmem_rvalid) begin
            r_ld    <= w_ld;
            r_state <= S_RESP;
          end else if (w_tmo) begin
            r_exc   <= 1'b1;
            r_cause <= EXC_TIMEOUT;
            r_state <= S_RESP;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        S_RESP: begin
          r_wb_valid  <= 1'b1;
          r_wb_rw     <= r_rw & ~r_exc & ~r_store;
          r_wb_rd     <= r_exc ? 5'd0 : r_rd;
          r_wb_data   <= (r_exc | r_store) ? 32'h0 : r_ld;
          r_exc_valid <= r_exc;
          r_exc_cause <= r_cause;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage:
// directed ops, modelled memory, beat monitor.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  typedef struct packed {
    logic        cd;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    logic [1:0]  cause;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [4:0]  rd_in = 5'd0;
  logic        reg_write_in = 1'b0;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [1:0]  exc_cause;

  mem_access_stage_if dmem();

  int checks = 0;
  int errors = 0;
  beat_t exp_q[$];

  int          cfg_gnt_delay = 0;
  bit          cfg_rsp_en = 1'b1;
  logic [31:0] cfg_rdata = 32'h0;
  int          late_req = 0;
  int          late_ack = 0;
  int          req_cnt = 0;
  int          gcnt = 0;
  bit          pend = 1'b0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .rd_in        (rd_in),
    .reg_write_in (reg_write_in),
    .dmem         (dmem.master),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .exc_valid    (exc_valid),
    .exc_cause    (exc_cause)
  );

  function automatic beat_t mk(
    input logic cd, input logic rw,
    input logic [4:0] rd, input logic [31:0] d,
    input logic exc, input logic [1:0] cause);
    beat_t b;
    b.cd = cd; b.rw = rw; b.rd = rd;
    b.data = d; b.exc = exc; b.cause = cause;
    return b;
  endfunction

  task automatic chk(input string nm,
    input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // memory model: gnt after cfg_gnt_delay req cycles, rvalid next cycle
  initial begin
    dmem.dmem_gnt = 1'b0;
    dmem.dmem_rvalid = 1'b0;
    dmem.dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      dmem.dmem_gnt = 1'b0;
      dmem.dmem_rvalid = 1'b0;
      if (rst) begin
        gcnt = 0;
        pend = 1'b0;
      end
      if (dmem.dmem_req) req_cnt++;
      if ((pend && cfg_rsp_en) || late_req != late_ack) begin
        dmem.dmem_rvalid = 1'b1;
        dmem.dmem_rdata = cfg_rdata;
      end
      pend = 1'b0;
      late_ack = late_req;
      if (dmem.dmem_req && !rst) begin
        if (gcnt >= cfg_gnt_delay) begin
          dmem.dmem_gnt = 1'b1;
          pend = !dmem.dmem_we;
          gcnt = 0;
        end else begin
          gcnt++;
        end
      end
    end
  end

  // monitor: every beat must match the oldest expectation
  initial begin
    beat_t e;
    bit ok;
    forever begin
      @(negedge clk);
      if (wb_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: rd=%0d data=%h exc=%b cause=%b",
            wb_rd, wb_data, exc_valid, exc_cause);
        end else begin
          e = exp_q.pop_front();
          ok = (wb_reg_write === e.rw) && (wb_rd === e.rd)
            && (exc_valid === e.exc) && (exc_cause === e.cause)
            && (!e.cd || wb_data === e.data);
          if (!ok) begin
            errors++;
            $display("FAIL beat: got rw=%b rd=%0d data=%h exc=%b cause=%b want rw=%b rd=%0d data=%h exc=%b cause=%b",
              wb_reg_write, wb_rd, wb_data, exc_valid, exc_cause,
              e.rw, e.rd, e.data, e.exc, e.cause);
          end
        end
      end
    end
  end

  task automatic issue(input logic mr, input logic mw,
    input logic [2:0] f3, input logic [31:0] a,
    input logic [31:0] sd, input logic [4:0] rd,
    input logic rw);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("issue_ready", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1;
    mem_read = mr; mem_write = mw; funct3 = f3;
    alu_result = a; store_data = sd;
    rd_in = rd; reg_write_in = rw;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending want 0",
        exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic run(input string nm,
    input logic mr, input logic mw, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] sd,
    input logic [31:0] rdat, input logic [4:0] rd,
    input beat_t e, input logic [3:0] ebe,
    input logic [31:0] ewd);
    int r0;
    cfg_rdata = rdat;
    exp_q.push_back(e);
    r0 = req_cnt;
    issue(mr, mw, f3, a, sd, rd, 1'b1);
    @(negedge clk);
    if (!e.exc && (mr || mw)) begin
      chk({nm, "_req"}, {31'h0, dmem.dmem_req}, 32'h1);
      chk({nm, "_addr"}, dmem.dmem_addr, {a[31:2], 2'b00});
      chk({nm, "_we"}, {31'h0, dmem.dmem_we}, {31'h0, mw});
      if (mw) begin
        chk({nm, "_be"}, {28'h0, dmem.dmem_be}, {28'h0, ebe});
        chk({nm, "_wdata"}, dmem.dmem_wdata, ewd);
      end
    end
    drain();
    if (!(mr || mw) || (e.exc && e.cause != 2'b10))
      chk({nm, "_noreq"}, req_cnt - r0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_req", {31'h0, dmem.dmem_req}, 32'h0);
    chk("rst_we", {31'h0, dmem.dmem_we}, 32'h0);
    chk("rst_addr", dmem.dmem_addr, 32'h0);
    chk("rst_be", {28'h0, dmem.dmem_be}, 32'h0);
    chk("rst_wdata", dmem.dmem_wdata, 32'h0);
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_wb_rw", {31'h0, wb_reg_write}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_exc_valid", {31'h0, exc_valid}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);

    exp_q.push_back(mk(1, 1, 5, 32'h1234_5678, 0, 0));
    issue(0, 0, F3_W, 32'h1234_5678, 0, 5, 1);
    @(negedge clk);
    chk("nonmem_latency", {31'h0, wb_valid}, 32'h1);
    drain();

    run("sb", 0, 1, F3_B, 32'h103, 32'hAB, 0, 7,
      mk(0, 0, 7, 0, 0, 0), 4'b1000, 32'hABAB_ABAB);
    run("sh", 0, 1, F3_H, 32'h102, 32'h1234_ABCD, 0, 8,
      mk(0, 0, 8, 0, 0, 0), 4'b1100, 32'hABCD_ABCD);
    run("sw", 0, 1, F3_W, 32'h400, 32'hCAFE_F00D, 0, 9,
      mk(0, 0, 9, 0, 0, 0), 4'b1111, 32'hCAFE_F00D);

    cfg_rdata = 32'h0080_0000;
    exp_q.push_back(mk(1, 1, 3, 32'hFFFF_FF80, 0, 0));
    issue(1, 0, F3_B, 32'h202, 0, 3, 1);
    repeat (3) @(negedge clk);
    chk("load_before", {31'h0, wb_valid}, 32'h0);
    @(negedge clk);
    chk("load_latency", {31'h0, wb_valid}, 32'h1);
    drain();

    run("lbu", 1, 0, F3_BU, 32'h202, 0, 32'h0080_0000, 4,
      mk(1, 1, 4, 32'h0000_0080, 0, 0), 0, 0);
    run("lh", 1, 0, F3_H, 32'h202, 0, 32'h0080_0000, 6,
      mk(1, 1, 6, 32'h0000_0080, 0, 0), 0, 0);
    run("lh_neg", 1, 0, F3_H, 32'h202, 0, 32'h8001_0000, 10,
      mk(1, 1, 10, 32'hFFFF_8001, 0, 0), 0, 0);
    run("lhu", 1, 0, F3_HU, 32'h202, 0, 32'h8001_0000, 11,
      mk(1, 1, 11, 32'h0000_8001, 0, 0), 0, 0);
    run("lb_off1", 1, 0, F3_B, 32'h201, 0, 32'h0000_FE00, 12,
      mk(1, 1, 12, 32'hFFFF_FFFE, 0, 0), 0, 0);
    run("lw", 1, 0, F3_W, 32'h200, 0, 32'hDEAD_BEEF, 13,
      mk(1, 1, 13, 32'hDEAD_BEEF, 0, 0), 0, 0);

    run("lw_mis", 1, 0, F3_W, 32'h301, 0, 0, 14,
      mk(1, 0, 0, 0, 1, 2'b01), 0, 0);
    run("lh_mis", 1, 0, F3_H, 32'h303, 0, 0, 15,
      mk(1, 0, 0, 0, 1, 2'b01), 0, 0);
    run("sh_hu", 0, 1, F3_HU, 32'h300, 32'h55, 0, 16,
      mk(1, 0, 0, 0, 1, 2'b11), 0, 0);
    run("f3_011", 1, 0, 3'b011, 32'h300, 0, 0, 17,
      mk(1, 0, 0, 0, 1, 2'b11), 0, 0);
    run("rd_wr", 1, 1, F3_W, 32'h300, 0, 0, 18,
      mk(1, 0, 0, 0, 1, 2'b11), 0, 0);

    cfg_gnt_delay = 3;
    cfg_rsp_en = 1'b0;
    exp_q.push_back(mk(1, 0, 0, 0, 1, 2'b10));
    issue(1, 0, F3_W, 32'h500, 0, 19, 1);
    repeat (9) @(negedge clk);
    chk("tmo_before", {31'h0, wb_valid}, 32'h0);
    @(negedge clk);
    chk("tmo_at", {31'h0, exc_valid}, 32'h1);
    late_req++;
    repeat (3) @(negedge clk);
    chk("tmo_late_ready", {31'h0, in_ready}, 32'h1);
    drain();
    cfg_rsp_en = 1'b1;
    run("lw_gnt3", 1, 0, F3_W, 32'h600, 0, 32'h1122_3344, 20,
      mk(1, 1, 20, 32'h1122_3344, 0, 0), 0, 0);

    cfg_gnt_delay = 0;
    cfg_rsp_en = 1'b0;
    issue(1, 0, F3_W, 32'h700, 0, 21, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstw_req", {31'h0, dmem.dmem_req}, 32'h0);
    chk("rstw_wb", {31'h0, wb_valid}, 32'h0);
    chk("rstw_ready", {31'h0, in_ready}, 32'h1);
    late_req++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstw_after", {31'h0, in_ready}, 32'h1);

    cfg_gnt_delay = 50;
    issue(1, 0, F3_W, 32'h800, 0, 22, 1);
    @(negedge clk);
    chk("rstq_req_on", {31'h0, dmem.dmem_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rstq_req_off", {31'h0, dmem.dmem_req}, 32'h0);
    chk("rstq_addr", dmem.dmem_addr, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    cfg_gnt_delay = 0;
    cfg_rsp_en = 1'b1;
    @(negedge clk);

    run("post_rst", 0, 0, F3_W, 32'hA5A5_A5A5, 0, 0, 9,
      mk(1, 1, 9, 32'hA5A5_A5A5, 0, 0), 0, 0);
    run("post_rst_lb", 1, 0, F3_B, 32'h903, 0, 32'h7F00_0000, 23,
      mk(1, 1, 23, 32'h0000_007F, 0, 0), 0, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
